tc_bus_sequencer: RTL and testbench

- Bus-side controller for a bank of TC-style registers.
- Each register exposes a save strobe (capture on clock edge) and a load strobe (combinational output enable, drives zero when not loaded).
- This block sequences those strobes to execute one transfer per command: register-to-register copy, immediate write, register read, or register clear.
- It sits between the instruction/control logic and the register bank, and owns the shared write bus and the ORed read bus.

---
 rtl/tc_bus_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_tc_bus_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tc_bus_sequencer
//
// Bus-side controller for a bank of TC-style registers. Each register has a
// save strobe (captures the shared write bus on the clock edge) and a load
// strobe (drives its value onto an ORed read bus, zero when not loaded).
// One command is executed per start: COPY, WRITE_IMM, READ or CLEAR.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous, active-low reset
//   start    - command valid, accepted only while idle
//   op       - 00 COPY, 01 WRITE_IMM, 10 READ, 11 CLEAR
//   src_sel  - source register index (COPY, READ)
//   dst_sel  - destination register index (COPY, WRITE_IMM, CLEAR)
//   imm      - immediate data for WRITE_IMM
//   bus_in   - OR of all register outputs
//   load     - one-hot output-enable strobes
//   save     - one-hot write strobes
//   bus_out  - write data to every register input, zero outside SAVE
//   rdata    - last value captured by a READ or COPY
//   busy     - high whenever a command is in progress
//   done     - one-cycle completion pulse
//   err      - one-cycle pulse with done when a select was out of range
// ---------------------------------------------------------------------------
module tc_bus_sequencer #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_REGS  = 8,
    parameter int SEL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [SEL_W-1:0]     src_sel,
    input  logic [SEL_W-1:0]     dst_sel,
    input  logic [BIT_WIDTH-1:0] imm,
    input  logic [BIT_WIDTH-1:0] bus_in,
    output logic [NUM_REGS-1:0]  load,
    output logic [NUM_REGS-1:0]  save,
    output logic [BIT_WIDTH-1:0] bus_out,
    output logic [BIT_WIDTH-1:0] rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SAVE = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [1:0] OP_COPY      = 2'b00;
    localparam logic [1:0] OP_WRITE_IMM = 2'b01;
    localparam logic [1:0] OP_READ      = 2'b10;
    localparam logic [1:0] OP_CLEAR     = 2'b11;

    // One extra bit so NUM_REGS itself is representable even when 2^SEL_W == NUM_REGS.
    localparam logic [SEL_W:0] NUM_REGS_C = (SEL_W + 1)'(NUM_REGS);

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [SEL_W-1:0]     src_q, src_d;
    logic [SEL_W-1:0]     dst_q, dst_d;
    logic [BIT_WIDTH-1:0] imm_q, imm_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic src_bad;
    logic dst_bad;
    logic sel_bad;

    // A select is only invalid if the requested op actually uses it.
    always_comb begin
        src_bad = ({1'b0, src_sel} >= NUM_REGS_C);
        dst_bad = ({1'b0, dst_sel} >= NUM_REGS_C);
        case (op)
            OP_COPY: sel_bad = src_bad | dst_bad;
            OP_READ: sel_bad = src_bad;
            default: sel_bad = dst_bad;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            imm_q   <= imm_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Command fields are latched only on acceptance so the strobes never
    // depend on live inputs; invalid commands skip straight to DONE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op;
                    src_d = src_sel;
                    dst_d = dst_sel;
                    imm_d = imm;
                    err_d = sel_bad;
                    if (sel_bad) begin
                        state_d = ST_DONE;
                    end else if ((op == OP_COPY) || (op == OP_READ)) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SAVE;
                    end
                end
            end
            ST_LOAD: begin
                data_d  = bus_in;
                rdata_d = bus_in;
                state_d = (op_q == OP_COPY) ? ST_SAVE : ST_DONE;
            end
            ST_SAVE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes and write data decode purely from registered state and fields.
    always_comb begin
        load    = '0;
        save    = '0;
        bus_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((state_q == ST_LOAD) && (src_q == SEL_W'(i))) begin
                load[i] = 1'b1;
            end
            if ((state_q == ST_SAVE) && (dst_q == SEL_W'(i))) begin
                save[i] = 1'b1;
            end
        end
        if (state_q == ST_SAVE) begin
            case (op_q)
                OP_COPY:      bus_out = data_q;
                OP_WRITE_IMM: bus_out = imm_q;
                default:      bus_out = '0;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign err   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_tc_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tc_bus_sequencer
//
// Drives tc_bus_sequencer against a small register bank, keeps an
// array-based reference of register contents, and compares the strobe
// schedule, busy, done/err timing, rdata and register contents through
// queues filled when a command is accepted and drained by a monitor.
// ---------------------------------------------------------------------------
module tb_tc_bus_sequencer;

    localparam int BW = 8;
    localparam int NR = 8;
    localparam int SW = 4;

    localparam logic [1:0] OP_COPY  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [SW-1:0] src_sel;
    logic [SW-1:0] dst_sel;
    logic [BW-1:0] imm;
    logic [BW-1:0] bus_in;
    logic [NR-1:0] load;
    logic [NR-1:0] save;
    logic [BW-1:0] bus_out;
    logic [BW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    tc_bus_sequencer #(.BIT_WIDTH(BW), .NUM_REGS(NR), .SEL_W(SW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src_sel (src_sel),
        .dst_sel (dst_sel),
        .imm     (imm),
        .bus_in  (bus_in),
        .load    (load),
        .save    (save),
        .bus_out (bus_out),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Register bank driven by the sequencer's strobes.
    logic [BW-1:0] bank [NR] = '{default: '0};

    always_comb begin
        bus_in = '0;
        for (int i = 0; i < NR; i++) begin
            if (load[i]) bus_in = bus_in | bank[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (save[i]) bank[i] <= bus_out;
        end
    end

    // Reference state
    typedef struct {
        int            edge_n;
        bit            bad;
        logic [BW-1:0] rd;
    } done_t;

    typedef struct {
        int            edge_n;
        logic [NR-1:0] ld;
        logic [NR-1:0] sv;
        logic [BW-1:0] bus;
    } strobe_t;

    done_t         dq[$];
    strobe_t       sq[$];
    logic [BW-1:0] ref_regs [NR] = '{default: '0};
    logic [BW-1:0] snap     [NR] = '{default: '0};
    logic [BW-1:0] ref_rdata = '0;
    int            edge_cnt = 0;
    int            next_accept = 0;
    int            last_accept = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Command accepted at edge e with latency L: done is high in the cycle
    // after edge e+L-1, and the next command can be taken at edge e+L+1.
    function automatic void accept(input int e);
        int      s;
        int      d;
        bit      bad;
        int      lat;
        done_t   de;
        strobe_t st;
        s = int'(src_sel);
        d = int'(dst_sel);
        case (op)
            OP_COPY: bad = (s >= NR) || (d >= NR);
            OP_READ: bad = (s >= NR);
            default: bad = (d >= NR);
        endcase
        snap = ref_regs;
        lat  = 1;
        if (!bad) begin
            st.ld = '0; st.sv = '0; st.bus = '0; st.edge_n = e;
            case (op)
                OP_COPY: begin
                    lat = 3;
                    st.ld[s] = 1'b1;
                    sq.push_back(st);
                    st.ld = '0; st.edge_n = e + 1; st.sv[d] = 1'b1; st.bus = ref_regs[s];
                    sq.push_back(st);
                    ref_rdata   = ref_regs[s];
                    ref_regs[d] = ref_regs[s];
                end
                OP_READ: begin
                    lat = 2;
                    st.ld[s] = 1'b1;
                    sq.push_back(st);
                    ref_rdata = ref_regs[s];
                end
                OP_WRITE: begin
                    lat = 2;
                    st.sv[d] = 1'b1; st.bus = imm;
                    sq.push_back(st);
                    ref_regs[d] = imm;
                end
                default: begin
                    lat = 2;
                    st.sv[d] = 1'b1;
                    sq.push_back(st);
                    ref_regs[d] = '0;
                end
            endcase
        end
        de.edge_n = e + lat - 1;
        de.bad    = bad;
        de.rd     = ref_rdata;
        dq.push_back(de);
        last_accept = e;
        next_accept = e + lat + 1;
    endfunction

    // An interrupted command leaves the registers as they were before it.
    task automatic model_reset();
        if ((dq.size() > 0) && (dq[0].edge_n > edge_cnt)) ref_regs = snap;
        dq.delete();
        sq.delete();
        next_accept = 0;
        ref_rdata   = '0;
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        if ((rst === 1'b1) && (start === 1'b1) && (edge_cnt >= next_accept)) accept(edge_cnt);
    end

    // Monitor
    always @(negedge clk) begin
        strobe_t exp_s;
        done_t   de;
        if (rst === 1'b1) begin
            exp_s.edge_n = 0; exp_s.ld = '0; exp_s.sv = '0; exp_s.bus = '0;
            if ((sq.size() > 0) && (sq[0].edge_n == edge_cnt)) exp_s = sq.pop_front();
            check_output("load", 32'(load), 32'(exp_s.ld));
            check_output("save", 32'(save), 32'(exp_s.sv));
            check_output("bus_out", 32'(bus_out), 32'(exp_s.bus));
            check_output("busy", 32'(busy), 32'((edge_cnt >= last_accept) && (edge_cnt < next_accept - 1)));
            if (done === 1'b1) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_done: got done=1 expected done=0 (edge %0d)", edge_cnt);
                end else begin
                    de = dq.pop_front();
                    check_output("done_edge", 32'(edge_cnt), 32'(de.edge_n));
                    check_output("err", 32'(err), 32'(de.bad));
                    check_output("rdata", 32'(rdata), 32'(de.rd));
                    for (int i = 0; i < NR; i++) begin
                        check_output("bank", 32'(bank[i]), 32'(ref_regs[i]));
                    end
                end
            end else begin
                check_output("err_no_done", 32'(err), 32'd0);
            end
            if ((dq.size() > 0) && (dq[0].edge_n < edge_cnt)) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_done: got none expected done at edge %0d", dq[0].edge_n);
                void'(dq.pop_front());
            end
        end
    end

    function automatic logic [SW-1:0] pick_sel();
        if ($urandom_range(0, 9) == 0) return SW'($urandom_range(NR, (1 << SW) - 1));
        return SW'($urandom_range(0, NR - 1));
    endfunction

    task automatic apply_stimulus(input logic [1:0] o, input int s, input int d, input logic [BW-1:0] v);
        @(posedge clk);
        #2;
        start   = 1'b1;
        op      = o;
        src_sel = SW'(s);
        dst_sel = SW'(d);
        imm     = v;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; op = '0; src_sel = '0; dst_sel = '0; imm = '0;
        #1;
        check_output("rst_load", 32'(load), 32'd0);
        check_output("rst_save", 32'(save), 32'd0);
        check_output("rst_bus_out", 32'(bus_out), 32'd0);
        check_output("rst_rdata", 32'(rdata), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Directed transfers
        apply_stimulus(OP_WRITE, 0, 3, 8'hA5);
        apply_stimulus(OP_COPY, 3, 6, 8'h00);
        apply_stimulus(OP_READ, 6, 0, 8'h00);
        apply_stimulus(OP_CLEAR, 0, 6, 8'h00);
        apply_stimulus(OP_READ, 6, 0, 8'h00);
        apply_stimulus(OP_COPY, 9, 1, 8'h00);
        apply_stimulus(OP_WRITE, 0, 12, 8'h5A);
        apply_stimulus(OP_READ, 15, 0, 8'h00);
        apply_stimulus(OP_COPY, 3, 3, 8'h00);
        apply_stimulus(OP_WRITE, 0, 1, 8'h3C);
        apply_stimulus(OP_WRITE, 0, 2, 8'h11);

        // Reset in the middle of the SAVE cycle of a COPY 1 -> 2
        @(posedge clk);
        #2;
        start = 1'b1; op = OP_COPY; src_sel = SW'(1); dst_sel = SW'(2);
        @(posedge clk);
        #2 start = 1'b0;
        @(posedge clk);
        #2;
        check_output("mid_save_strobe", 32'(save), 32'h04);
        check_output("mid_save_bus", 32'(bus_out), 32'h3C);
        rst = 1'b0;
        model_reset();
        #1;
        check_output("abort_load", 32'(load), 32'd0);
        check_output("abort_save", 32'(save), 32'd0);
        check_output("abort_bus_out", 32'(bus_out), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_rdata", 32'(rdata), 32'd0);
        @(posedge clk);
        #2;
        check_output("abort_dst_kept", 32'(bank[2]), 32'(ref_regs[2]));
        // start coincident with reset must be dropped
        start = 1'b1; op = OP_WRITE; dst_sel = SW'(4); imm = 8'h77;
        @(posedge clk);
        #2;
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        apply_stimulus(OP_READ, 2, 0, 8'h00);
        apply_stimulus(OP_READ, 4, 0, 8'h00);

        // start held high with rotating ops
        @(posedge clk);
        #2;
        for (int k = 0; k < 80; k++) begin
            start   = 1'b1;
            op      = 2'(k);
            src_sel = pick_sel();
            dst_sel = pick_sel();
            imm     = BW'($urandom);
            @(posedge clk);
            #2;
        end

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            start   = ($urandom_range(0, 3) != 0);
            op      = 2'($urandom_range(0, 3));
            src_sel = pick_sel();
            dst_sel = pick_sel();
            imm     = BW'($urandom);
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check_output("pending_done", 32'(dq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
